pn_ber_checker: RTL and testbench
=================================

// Module: pn_ber_checker
// PURPOSE
//   Receive-side PN5 bit-error-rate checker, directly downstream of the PN
//   generator / PSK demodulator bit output. Self-synchronises to the
//   x_n = x_{n-5} ^ x_{n-3} sequence (period 31) produced by the
//   transmit-side generator. Once locked, free-runs a local LFSR and counts
//   bit errors per fixed window. Drops lock when a window is too bad.
// PARAMETERS
//   N         5     LFSR length; only 5 supported (any other value: elaborate-time error)
//   LOCK_CNT  16    consecutive self-sync matches required to declare lock
//   WIN_LEN   1024  valid bits per measurement window (>=2)
//   LOSS_THR  64    window error count above which lock is dropped
//   CNT_W     16    width of window error count; must hold WIN_LEN
// PORTS
//   clk         in   1      system clock; all logic on rising edge
//   rst         in   1      synchronous, active-high reset
//   bit_in      in   1      received hard-decision bit
//   bit_valid   in   1      bit_in qualifier; one bit per high cycle
//   locked      out  1      high while in LOCKED state
//   win_done    out  1      1-cycle pulse: window complete, win_errs updated
//   win_errs    out  CNT_W  error count of last completed window (held)
//   lock_lost   out  1      1-cycle pulse when LOCKED -> SEARCH
//   total_errs  out  32     errors since reset, LOCKED only, saturates at 2^32-1
// BEHAVIOUR
// - Reset: state=SEARCH, hist=0, lfsr=0, fill=0, match_cnt=0, win/err counters=0,
//   all outputs 0. Reset overrides bit_valid; a partial window is discarded.
// - Nothing changes on cycles with bit_valid=0; pulses are low on those cycles.
// - hist[4:0] shifts every valid bit: hist <= {hist[3:0], bit_in} (hist[0] = newest).
// - SEARCH:
//   - fill counts the first 5 valid bits after reset; no comparison until fill==5.
//     fill is not cleared on lock loss.
//   - pred = hist[4]^hist[2] (pre-shift hist).
//   - match: bit_in==pred and hist!=0 -> match_cnt++.
//   - else match_cnt <= 0.
//   - When a match makes match_cnt==LOCK_CNT:
//     - state <= LOCKED;
//     - lfsr <= {hist[3:0],bit_in};
//     - clear window bit/error counters;
//     - locked rises at that same edge.
// - LOCKED:
//   - exp = lfsr[4]^lfsr[2]; lfsr <= {lfsr[3:0],exp}.
//   - The received bit is not fed back into lfsr.
//   - err = bit_in ^ exp.
//   - Per valid bit: win_bits++, win_acc += err, total_errs += err (saturating).
//   - On the bit making win_bits==WIN_LEN:
//     - win_errs <= win_acc+err; win_done=1 at that edge;
//     - counters restart at 0.
//     - If win_acc+err > LOSS_THR (same edge): state <= SEARCH, lock_lost=1,
//       locked=0, match_cnt=0.
//   - Loss is evaluated only at window end, never mid-window.
// - lfsr==0 in LOCKED cannot occur (seeded from nonzero hist). If forced, treat it
//   as loss at the next valid bit: lock_lost=1, no win_done.
// - Latency: every output changes on the edge that samples the qualifying valid bit.
// - win_errs holds its value across lock loss and SEARCH; cleared only by rst.
// TESTING
// 1. Clean PN5 stream, any nonzero phase, bit_valid=1 continuously:
//    - locked rises at edge of bit 21 (5 fill + 16 matches);
//    - win_done every 1024 bits thereafter, win_errs=0, total_errs=0.
// 2. Locked, invert bits at 10 chosen positions in one window:
//    - that window win_errs=10, next window 0; total_errs=10; locked stays 1.
// 3. Single inverted bit at bit 12 in SEARCH:
//    - match_cnt restarts; locked rises later than in case 1
//      (exact edge computed by bench model);
//    - no win_done before lock.
// 4. Locked, then switch to all-ones / random stream:
//    - window end gives win_errs>64, win_done=1 and lock_lost=1 same edge, locked=0;
//    - relocks 16 matches after clean PN resumes.
// 5. Clean stream with random bit_valid gaps (~50% duty):
//    - identical lock point and win_errs in valid-bit count to case 1.
// 6. rst pulse at bit 500 of a window while locked:
//    - next edge all outputs 0, state SEARCH, total_errs=0;
//    - relock after 21 valid bits.

Source files
------------

// File: rtl/pn_ber_checker.sv
// PN5 (x^5 + x^3 + 1) receive-side bit-error-rate checker: self-synchronises on the
// incoming stream, then free-runs a local LFSR and reports per-window error counts.
module pn_ber_checker #(
   parameter int N        = 5,
   parameter int LOCK_CNT = 16,
   parameter int WIN_LEN  = 1024,
   parameter int LOSS_THR = 64,
   parameter int CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             bit_in,
   input  logic             bit_valid,
   output logic             locked,
   output logic             win_done,
   output logic [CNT_W-1:0] win_errs,
   output logic             lock_lost,
   output logic [31:0]      total_errs
);

   generate
      if (N != 5) begin : g_bad_n
         $error("pn_ber_checker: only N=5 is supported");
      end
      if (WIN_LEN < 2) begin : g_bad_win
         $error("pn_ber_checker: WIN_LEN must be at least 2");
      end
      if (64'(WIN_LEN) >= (64'd1 << CNT_W)) begin : g_bad_cnt_w
         $error("pn_ber_checker: CNT_W too narrow for WIN_LEN");
      end
   endgenerate

   localparam int MC_W = $clog2(LOCK_CNT + 1);

   localparam logic [0:0]       ST_SEARCH = 1'b0;
   localparam logic [0:0]       ST_LOCKED = 1'b1;
   localparam logic [2:0]       FILL_DONE = 3'd5;
   localparam logic [MC_W-1:0]  LOCK_TGT  = MC_W'(LOCK_CNT - 1);
   localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN_LEN - 1);
   localparam logic [CNT_W-1:0] LOSS_LIM  = CNT_W'(LOSS_THR);

   // Saturating 32-bit increment for the running error total.
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic inc);
      if (inc && (value != 32'hFFFF_FFFF)) begin
         return value + 32'd1;
      end
      return value;
   endfunction

   logic [0:0]       state;
   logic [4:0]       hist;
   logic [4:0]       lfsr;
   logic [2:0]       fill;
   logic [MC_W-1:0]  match_cnt;
   logic [CNT_W-1:0] win_bits;
   logic [CNT_W-1:0] win_acc;

   logic             pred;
   logic             match;
   logic             exp_bit;
   logic             err;
   logic [CNT_W-1:0] acc_next;
   logic             win_end;
   logic             too_bad;

   always_comb begin
      pred     = hist[4] ^ hist[2];
      match    = (bit_in == pred) && (hist != 5'd0);
      exp_bit  = lfsr[4] ^ lfsr[2];
      err      = bit_in ^ exp_bit;
      acc_next = win_acc + CNT_W'(err);
      win_end  = (win_bits == WIN_LAST);
      too_bad  = (acc_next > LOSS_LIM);
   end

   assign locked = (state == ST_LOCKED);

   // Stage p0: every register updates on the edge that samples a valid bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_SEARCH;
         hist       <= 5'd0;
         lfsr       <= 5'd0;
         fill       <= 3'd0;
         match_cnt  <= '0;
         win_bits   <= '0;
         win_acc    <= '0;
         win_errs   <= '0;
         win_done   <= 1'b0;
         lock_lost  <= 1'b0;
         total_errs <= 32'd0;
      end else begin
         win_done  <= 1'b0;
         lock_lost <= 1'b0;
         if (bit_valid) begin
            hist <= {hist[3:0], bit_in};
            if (state == ST_SEARCH) begin
               if (fill != FILL_DONE) begin
                  fill <= fill + 3'd1;
               end else if (match) begin
                  if (match_cnt == LOCK_TGT) begin
                     // Seed the local generator with the five most recent received bits.
                     state     <= ST_LOCKED;
                     lfsr      <= {hist[3:0], bit_in};
                     match_cnt <= '0;
                     win_bits  <= '0;
                     win_acc   <= '0;
                  end else begin
                     match_cnt <= match_cnt + MC_W'(1);
                  end
               end else begin
                  match_cnt <= '0;
               end
            end else if (lfsr == 5'd0) begin
               // Stuck generator can never produce a sensible reference; resynchronise.
               state     <= ST_SEARCH;
               lock_lost <= 1'b1;
               match_cnt <= '0;
               win_bits  <= '0;
               win_acc   <= '0;
            end else begin
               lfsr       <= {lfsr[3:0], exp_bit};
               total_errs <= sat_inc(total_errs, err);
               if (win_end) begin
                  win_errs <= acc_next;
                  win_done <= 1'b1;
                  win_bits <= '0;
                  win_acc  <= '0;
                  if (too_bad) begin
                     state     <= ST_SEARCH;
                     lock_lost <= 1'b1;
                     match_cnt <= '0;
                  end
               end else begin
                  win_bits <= win_bits + CNT_W'(1);
                  win_acc  <= acc_next;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_pn_ber_checker.sv
// Bench for pn_ber_checker: a reference model feeds a scoreboard compared every cycle,
// and each scenario task adds its own targeted checks.
module tb_pn_ber_checker;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             bit_in = 1'b0;
   logic             bit_valid = 1'b0;
   logic             locked;
   logic             win_done;
   logic [CNT_W-1:0] win_errs;
   logic             lock_lost;
   logic [31:0]      total_errs;

   always #5 clk = ~clk;

   pn_ber_checker #(
      .N(5), .LOCK_CNT(16), .WIN_LEN(1024), .LOSS_THR(64), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
      .locked(locked), .win_done(win_done), .win_errs(win_errs),
      .lock_lost(lock_lost), .total_errs(total_errs)
   );

   typedef logic [CNT_W+34:0] obs_t;
   obs_t sb_q[$];
   int checks = 0;
   int errors = 0;

   // reference model state
   logic             m_search;
   logic [4:0]       m_hist;
   logic [4:0]       m_lfsr;
   int               m_fill;
   int               m_match;
   int               m_wbits;
   int               m_wacc;
   logic [CNT_W-1:0] m_werrs;
   logic [31:0]      m_total;
   logic             m_done;
   logic             m_lost;

   // transmit-side generator and observation bookkeeping
   logic [4:0] gen = 5'b10110;
   int vcount = 0;
   int lock_at = -1;
   int done_cnt = 0;
   int last_done_at = -1;
   logic was_locked = 1'b0;

   task automatic pn_bit(output logic b);
      b = gen[4] ^ gen[2];
      gen = {gen[3:0], b};
   endtask

   task automatic model_reset();
      m_search = 1'b1; m_hist = 5'd0; m_lfsr = 5'd0; m_fill = 0; m_match = 0;
      m_wbits = 0; m_wacc = 0; m_werrs = '0; m_total = 32'd0; m_done = 1'b0; m_lost = 1'b0;
   endtask

   task automatic model_step(input logic b, input logic v);
      logic [4:0] pre;
      logic ex;
      logic er;
      m_done = 1'b0;
      m_lost = 1'b0;
      if (v) begin
         pre = m_hist;
         if (m_search) begin
            if (m_fill < 5) m_fill++;
            else if ((b == (pre[4] ^ pre[2])) && (pre != 5'd0)) begin
               m_match++;
               if (m_match == 16) begin
                  m_search = 1'b0; m_lfsr = {pre[3:0], b}; m_match = 0; m_wbits = 0; m_wacc = 0;
               end
            end else m_match = 0;
         end else begin
            ex = m_lfsr[4] ^ m_lfsr[2];
            m_lfsr = {m_lfsr[3:0], ex};
            er = b ^ ex;
            if (er && (m_total != 32'hFFFF_FFFF)) m_total++;
            m_wbits++;
            m_wacc += int'(er);
            if (m_wbits == 1024) begin
               m_werrs = CNT_W'(m_wacc);
               m_done = 1'b1;
               if (m_wacc > 64) begin
                  m_search = 1'b1; m_lost = 1'b1; m_match = 0;
               end
               m_wbits = 0; m_wacc = 0;
            end
         end
         m_hist = {pre[3:0], b};
      end
   endtask

   // Scoreboard: one expected output vector per driven cycle.
   always @(posedge clk) begin
      obs_t e;
      #1;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checks++;
         if ({locked, win_done, lock_lost, win_errs, total_errs} !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t got locked=%b done=%b lost=%b win_errs=%0d total=%0d want locked=%b done=%b lost=%b win_errs=%0d total=%0d",
                     $time, locked, win_done, lock_lost, win_errs, total_errs,
                     e[CNT_W+34], e[CNT_W+33], e[CNT_W+32], e[CNT_W+31:32], e[31:0]);
         end
      end
   end

   task automatic send(input logic b, input logic v);
      @(negedge clk);
      rst = 1'b0;
      bit_in = b;
      bit_valid = v;
      model_step(b, v);
      sb_q.push_back({~m_search, m_done, m_lost, m_werrs, m_total});
      @(posedge clk);
      #2;
      if (v) vcount++;
      if (locked && !was_locked && (lock_at < 0)) lock_at = vcount;
      was_locked = locked;
      if (win_done) begin
         done_cnt++;
         last_done_at = vcount;
      end
   endtask

   task automatic do_reset(input logic v);
      @(negedge clk);
      rst = 1'b1;
      bit_valid = v;
      bit_in = 1'b1;
      model_reset();
      sb_q.push_back('0);
      @(posedge clk);
      #2;
      vcount = 0; lock_at = -1; done_cnt = 0; last_done_at = -1; was_locked = 1'b0;
   endtask

   task automatic send_clean(input int n);
      logic b;
      for (int i = 0; i < n; i++) begin
         pn_bit(b);
         send(b, 1'b1);
      end
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      checks++;
      if ({locked, win_done, lock_lost, win_errs, total_errs} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got locked=%b done=%b lost=%b win_errs=%0d total=%0d want all 0",
                  locked, win_done, lock_lost, win_errs, total_errs);
      end
   endtask

   task automatic test_clean_lock();
      do_reset(1'b0);
      gen = 5'b10110;
      send_clean(21 + 2048);
      checks++;
      if (lock_at !== 21) begin errors++; $display("FAIL clean_lock_edge got %0d want 21", lock_at); end
      checks++;
      if (done_cnt !== 2) begin errors++; $display("FAIL clean_window_count got %0d want 2", done_cnt); end
      checks++;
      if (last_done_at !== 2069) begin errors++; $display("FAIL clean_window_edge got %0d want 2069", last_done_at); end
      checks++;
      if ({win_errs, total_errs} !== '0) begin
         errors++; $display("FAIL clean_error_counts got win_errs=%0d total=%0d want 0 0", win_errs, total_errs);
      end
   endtask

   task automatic test_error_window();
      int pos[10] = '{1, 7, 100, 101, 333, 512, 700, 901, 1000, 1024};
      logic b;
      logic flip;
      for (int i = 1; i <= 1024; i++) begin
         flip = 1'b0;
         foreach (pos[k]) if (pos[k] == i) flip = 1'b1;
         pn_bit(b);
         send(b ^ flip, 1'b1);
      end
      checks++;
      if (win_done !== 1'b1 || win_errs !== 16'd10) begin
         errors++; $display("FAIL err_window got done=%b win_errs=%0d want 1 10", win_done, win_errs);
      end
      send_clean(1024);
      checks++;
      if (win_done !== 1'b1 || win_errs !== 16'd0) begin
         errors++; $display("FAIL err_next_window got done=%b win_errs=%0d want 1 0", win_done, win_errs);
      end
      checks++;
      if (total_errs !== 32'd10 || locked !== 1'b1) begin
         errors++; $display("FAIL err_total got total=%0d locked=%b want 10 1", total_errs, locked);
      end
   endtask

   task automatic test_search_glitch();
      logic b;
      do_reset(1'b0);
      gen = 5'b00111;
      for (int i = 1; i <= 60; i++) begin
         pn_bit(b);
         send(b ^ (i == 12), 1'b1);
      end
      checks++;
      if (lock_at !== 33) begin errors++; $display("FAIL glitch_lock_edge got %0d want 33", lock_at); end
      checks++;
      if (done_cnt !== 0) begin errors++; $display("FAIL glitch_no_window got %0d want 0", done_cnt); end
   endtask

   task automatic test_loss_relock();
      logic [CNT_W-1:0] lost_errs;
      int resume_at;
      do_reset(1'b0);
      gen = 5'b11001;
      send_clean(21);
      for (int i = 0; i < 1024; i++) send(1'b1, 1'b1);
      checks++;
      if (win_done !== 1'b1 || lock_lost !== 1'b1 || locked !== 1'b0 || win_errs <= 16'd64) begin
         errors++;
         $display("FAIL loss_edge got done=%b lost=%b locked=%b win_errs=%0d want 1 1 0 >64",
                  win_done, lock_lost, locked, win_errs);
      end
      lost_errs = win_errs;
      lock_at = -1;
      resume_at = vcount;
      send_clean(30);
      checks++;
      if (lock_at < resume_at + 16 || lock_at > resume_at + 21) begin
         errors++; $display("FAIL relock_edge got %0d want %0d..%0d", lock_at, resume_at + 16, resume_at + 21);
      end
      checks++;
      if (win_errs !== lost_errs) begin
         errors++; $display("FAIL win_errs_held got %0d want %0d", win_errs, lost_errs);
      end
   endtask

   task automatic test_gaps();
      logic b;
      int cycles = 0;
      do_reset(1'b0);
      gen = 5'b10110;
      while (vcount < 1045 && cycles < 20000) begin
         if ($urandom_range(0, 1) == 1) begin
            pn_bit(b);
            send(b, 1'b1);
         end else begin
            send(1'($urandom_range(0, 1)), 1'b0);
         end
         cycles++;
      end
      checks++;
      if (vcount !== 1045) begin errors++; $display("FAIL gaps_budget got %0d valid bits want 1045", vcount); end
      checks++;
      if (lock_at !== 21) begin errors++; $display("FAIL gaps_lock_edge got %0d want 21", lock_at); end
      checks++;
      if (last_done_at !== 1045 || win_errs !== 16'd0) begin
         errors++; $display("FAIL gaps_window got at=%0d win_errs=%0d want 1045 0", last_done_at, win_errs);
      end
   endtask

   task automatic test_reset_midwindow();
      logic b;
      do_reset(1'b0);
      gen = 5'b01011;
      send_clean(21);
      for (int i = 1; i <= 500; i++) begin
         pn_bit(b);
         send(b ^ (i % 150 == 0), 1'b1);
      end
      checks++;
      if (total_errs !== 32'd3) begin errors++; $display("FAIL midwin_pre_total got %0d want 3", total_errs); end
      do_reset(1'b1);
      checks++;
      if ({locked, win_done, lock_lost, win_errs, total_errs} !== '0) begin
         errors++;
         $display("FAIL midwin_reset got locked=%b done=%b lost=%b win_errs=%0d total=%0d want all 0",
                  locked, win_done, lock_lost, win_errs, total_errs);
      end
      send_clean(25);
      checks++;
      if (lock_at !== 21) begin errors++; $display("FAIL midwin_relock got %0d want 21", lock_at); end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_clean_lock();
      test_error_window();
      test_search_glitch();
      test_loss_relock();
      test_gaps();
      test_reset_midwindow();
      @(negedge clk);
      bit_valid = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      checks++;
      if (sb_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain got %0d left want 0", sb_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
